dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache controller for the MEM stage.
- Takes CPU load/store requests from EX/MEM.
- Returns read data and a stall to the MEM/WB register and the hazard/stall network.
- Performs whole-line writeback and refill transfers with off-chip data memory over an enable/ack handshake.

Parameters:
- NUM_LINES, 16, cache lines; power of two; index width IDX_W = log2(NUM_LINES).
- LINE_W, 256, bits per line (32 bytes, 8 words).
- ADDR_W, 32, byte address width; tag width TAG_W = ADDR_W - IDX_W - 5.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- cpu_addr_i  in  ADDR_W  byte address; [4:2] word offset, [IDX_W+4:5] index, upper bits tag; [1:0] ignored.
- cpu_data_i  in  32  store data.
- cpu_MemRead_i  in  1  load request.
- cpu_MemWrite_i  in  1  store request; wins if both request inputs are high.
- cpu_data_o  out  32  load data (combinational on hit).
- cpu_stall_o  out  1  pipeline stall (combinational).
- mem_addr_o  out  ADDR_W  line-aligned memory address ([4:0]=0).
- mem_data_o  out  LINE_W  writeback line.
- mem_enable_o  out  1  memory request, held until ack.
- mem_write_o  out  1  1=writeback, 0=refill read.
- mem_data_i  in  LINE_W  refill line, valid with ack.
- mem_ack_i  in  1  one-cycle completion pulse.

Behaviour:
- Storage per line: valid, dirty, tag[TAG_W], data[LINE_W]. Arrays are registers, not reset except valid/dirty.
- hit = req & valid[idx] & (tag[idx]==addr tag), where req = MemRead | MemWrite.
- cpu_stall_o = req & !hit.
- cpu_data_o:
  - Read hit: word addr[4:2] of the line.
  - Otherwise: 0.
- Write hit, at the clock edge while stall is low:
  - Replace word addr[4:2] with cpu_data_i.
  - Set dirty. Valid and tag unchanged.
- FSM states: IDLE, WRITEBACK, REFILL, DONE.
  - IDLE: on req & !hit, go to WRITEBACK if valid&dirty, else go to REFILL. Otherwise stay in IDLE.
  - WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={old tag, idx, 5'b0}, mem_data_o=line. Go to REFILL on mem_ack_i.
  - REFILL: mem_enable_o=1, mem_write_o=0, mem_addr_o={new tag, idx, 5'b0}. On mem_ack_i, write mem_data_i into the line, set valid=1, dirty=0, tag=new tag, and go to DONE.
  - DONE: one cycle. The lookup now hits, so stall drops in this cycle. A store completes here (dirty set). Go to IDLE.
- Memory outputs are registered from state and are 0 in IDLE/DONE (addr/data values are don't-care there, but are driven to 0).
- Latency:
  - Hit: 0 cycles, no stall.
  - Clean miss: 1 + memory latency + 1 (DONE) cycles of stall.
  - Dirty miss: adds the writeback latency.
- mem_ack_i arriving in IDLE or DONE is ignored.
- CPU inputs must be held stable while cpu_stall_o=1. The controller latches nothing from the CPU except on the IDLE->miss decision; idx/tag are re-read from cpu_addr_i.
- Reset:
  - State goes to IDLE.
  - All valid and dirty bits are cleared.
  - mem_enable_o=0 and mem_write_o=0 from the cycle after rst_i is sampled.
  - Reset mid-transfer abandons the transfer; a late ack is ignored.
  - After reset every request misses.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, WRITEBACK=2'd1, REFILL=2'd2, DONE=2'd3); offset width 5; word-select width 3.
- Sub-module: dcache_sram holds the tag/valid/dirty/data arrays, with single-port read-combinational / write-synchronous access and separate full-line and word write enables.
- The FSM and hit logic live in dcache_ctrl.

Test Plan:
- Reset, then load addr 0x0000_0040 with memory latency 10 and the line's word 0 = 0xDEADBEEF:
  - Stall high for 12 cycles, then cpu_data_o=0xDEADBEEF.
  - mem_write_o=0 throughout.
- Load 0x44 immediately after: hit, no stall, returns word 1 of the same line.
- Store 0x1234_5678 to 0x48 (hit), then load 0x48: returns 0x12345678, no stall, dirty set.
- Load 0x248 (same index, different tag) with the line dirty:
  - WRITEBACK with mem_addr_o=0x40 and mem_data_o word 2 = 0x12345678.
  - Then REFILL with mem_addr_o=0x240.
  - Stall stays high until DONE.
- Store miss to clean line at 0x400: refill, then word written in DONE; a subsequent load of 0x400 returns the stored value with no stall.
- Assert rst_i during REFILL, then pulse mem_ack_i:
  - No line becomes valid.
  - mem_enable_o=0.
  - Next load of the same address misses again.

Source files
------------

// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the direct-mapped L1 data cache controller.
package dcache_ctrl_pkg;

    // Controller state encoding
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_REFILL    = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    localparam int OFS_W  = 5;    // byte offset within a 32-byte line
    localparam int WSEL_W = 3;    // word select within a line
    localparam int WORD_W = 32;

    // Extract one 32-bit word from a 256-bit line
    function automatic logic [WORD_W-1:0] line_word(input logic [255:0] line,
                                                    input logic [WSEL_W-1:0] sel);
        return line[{sel, 5'b0} +: WORD_W];
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage for the data cache: combinational read,
// synchronous write, with a full-line refill port and a single-word store port.
module dcache_sram
    import dcache_ctrl_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int LINE_W    = 256,
    parameter int TAG_W     = 23,
    parameter int IDX_W     = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic              valid_o,
    output logic              dirty_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [LINE_W-1:0] line_o,
    input  logic              line_we_i,
    input  logic [TAG_W-1:0]  line_tag_i,
    input  logic [LINE_W-1:0] line_data_i,
    input  logic              word_we_i,
    input  logic [WSEL_W-1:0] word_sel_i,
    input  logic [WORD_W-1:0] word_data_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];

    // Status bits: cleared by reset, refill makes a line valid and clean, a store dirties it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (word_we_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; validity is tracked by valid_q alone
    always_ff @(posedge clk_i) begin
        if (line_we_i) begin
            tag_q[idx_i]  <= line_tag_i;
            data_q[idx_i] <= line_data_i;
        end else if (word_we_i) begin
            data_q[idx_i][{word_sel_i, 5'b0} +: WORD_W] <= word_data_i;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Hits complete in zero cycles; misses stall while the FSM writes back the
// victim (if dirty) and refills the line over the memory enable/ack handshake.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int LINE_W    = 256,
    parameter int ADDR_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    input  logic              cpu_MemRead_i,
    input  logic              cpu_MemWrite_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFS_W;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [WSEL_W-1:0] wsel;
    logic [1:0]        unused_addr_lsb;

    logic              sram_valid;
    logic              sram_dirty;
    logic [TAG_W-1:0]  sram_tag;
    logic [LINE_W-1:0] sram_line;

    logic              req;
    logic              hit;
    logic              line_we;
    logic              word_we;

    state_t            state_q;
    logic              mem_enable_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [LINE_W-1:0] mem_data_q;

    assign idx             = cpu_addr_i[IDX_W+OFS_W-1:OFS_W];
    assign tag             = cpu_addr_i[ADDR_W-1:IDX_W+OFS_W];
    assign wsel            = cpu_addr_i[OFS_W-1:2];
    assign unused_addr_lsb = cpu_addr_i[1:0];

    assign req         = cpu_MemRead_i | cpu_MemWrite_i;
    assign hit         = req & sram_valid & (sram_tag == tag);
    assign cpu_stall_o = req & ~hit;

    // A store takes priority over a load, so read data is only returned for pure loads
    assign cpu_data_o = (hit & cpu_MemRead_i & ~cpu_MemWrite_i) ? line_word(sram_line, wsel) : 32'h0;

    // Stores land on a hit: directly from IDLE, or in DONE after a store miss refills
    assign word_we = hit & cpu_MemWrite_i & ~rst_i;
    assign line_we = (state_q == S_REFILL) & mem_ack_i & ~rst_i;

    dcache_sram #(
        .NUM_LINES (NUM_LINES),
        .LINE_W    (LINE_W),
        .TAG_W     (TAG_W),
        .IDX_W     (IDX_W)
    ) u_sram (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .idx_i       (idx),
        .valid_o     (sram_valid),
        .dirty_o     (sram_dirty),
        .tag_o       (sram_tag),
        .line_o      (sram_line),
        .line_we_i   (line_we),
        .line_tag_i  (tag),
        .line_data_i (mem_data_i),
        .word_we_i   (word_we),
        .word_sel_i  (wsel),
        .word_data_i (cpu_data_i)
    );

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

    // Miss-handling FSM with registered memory-side outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req & ~hit) begin
                        mem_enable_q <= 1'b1;
                        if (sram_valid & sram_dirty) begin
                            state_q     <= S_WRITEBACK;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= {sram_tag, idx, {OFS_W{1'b0}}};
                            mem_data_q  <= sram_line;
                        end else begin
                            state_q     <= S_REFILL;
                            mem_write_q <= 1'b0;
                            mem_addr_q  <= {tag, idx, {OFS_W{1'b0}}};
                            mem_data_q  <= '0;
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (mem_ack_i) begin
                        state_q     <= S_REFILL;
                        mem_write_q <= 1'b0;
                        mem_addr_q  <= {tag, idx, {OFS_W{1'b0}}};
                        mem_data_q  <= '0;
                    end
                end
                S_REFILL: begin
                    if (mem_ack_i) begin
                        state_q      <= S_DONE;
                        mem_enable_q <= 1'b0;
                        mem_write_q  <= 1'b0;
                        mem_addr_q   <= '0;
                        mem_data_q   <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: stimulus pushes expected CPU completions and
// memory requests into queues; monitors pop and compare as the DUT presents them.
module tb_dcache_ctrl;

    localparam int LAT = 10;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [31:0]  cpu_addr_i = '0;
    logic [31:0]  cpu_data_i = '0;
    logic         cpu_MemRead_i = 1'b0;
    logic         cpu_MemWrite_i = 1'b0;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [255:0] mem_data_i = '0;
    logic         model_ack = 1'b0;
    logic         force_ack = 1'b0;
    logic         mem_ack;

    assign mem_ack = model_ack | force_ack;

    dcache_ctrl dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cpu_addr_i     (cpu_addr_i),
        .cpu_data_i     (cpu_data_i),
        .cpu_MemRead_i  (cpu_MemRead_i),
        .cpu_MemWrite_i (cpu_MemWrite_i),
        .cpu_data_o     (cpu_data_o),
        .cpu_stall_o    (cpu_stall_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_enable_o   (mem_enable_o),
        .mem_write_o    (mem_write_o),
        .mem_data_i     (mem_data_i),
        .mem_ack_i      (mem_ack)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          rd;
        logic [31:0] data;
        int          stall;
    } cpu_exp_t;

    typedef struct {
        logic [31:0] addr;
        bit          wr;
        logic [31:0] w0;
        logic [31:0] w2;
    } mem_exp_t;

    cpu_exp_t cpu_q[$];
    mem_exp_t mem_q[$];

    int n_vec = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;
    bit mem_auto = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Memory contents: word i of the line at A is 0xA0000000|A|i, except word 0 of line 0x40
    function automatic logic [255:0] line_for(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'hA000_0000 | a | i;
        if (a == 32'h40) l[31:0] = 32'hDEADBEEF;
        return l;
    endfunction

    // Memory model and request monitor
    initial begin
        int cnt = 0;
        mem_exp_t m;
        forever begin
            @(posedge clk_i);
            #1;
            if (model_ack) begin
                model_ack = 1'b0;
                cnt = 0;
            end
            if (mem_auto && mem_enable_o) begin
                if (cnt == 0) begin
                    if (mem_q.size() == 0) begin
                        check("unexpected_mem_req", {32'h0, mem_addr_o}, 64'hFFFF_FFFF);
                    end else begin
                        m = mem_q.pop_front();
                        check("mem_addr", {32'h0, mem_addr_o}, {32'h0, m.addr});
                        check("mem_write", {63'h0, mem_write_o}, {63'h0, m.wr});
                        if (m.wr) begin
                            check("wb_word0", {32'h0, mem_data_o[31:0]}, {32'h0, m.w0});
                            check("wb_word2", {32'h0, mem_data_o[95:64]}, {32'h0, m.w2});
                        end
                    end
                end
                if (cnt == LAT) begin
                    model_ack = 1'b1;
                    mem_data_i = line_for(mem_addr_o);
                end
                cnt++;
            end else begin
                cnt = 0;
            end
        end
    end

    // CPU completion monitor: counts stall cycles and checks data when a request completes
    initial begin
        int stall_cnt = 0;
        cpu_exp_t e;
        forever begin
            @(negedge clk_i);
            if (mon_en && (cpu_MemRead_i || cpu_MemWrite_i)) begin
                if (cpu_stall_o) begin
                    stall_cnt++;
                end else begin
                    if (cpu_q.size() == 0) begin
                        check("unexpected_completion", {32'h0, cpu_addr_i}, 64'hFFFF_FFFF);
                    end else begin
                        e = cpu_q.pop_front();
                        check("stall_cycles", 64'(stall_cnt), 64'(e.stall));
                        check("cpu_data", {32'h0, cpu_data_o}, {32'h0, e.data});
                    end
                    stall_cnt = 0;
                end
            end
        end
    end

    task automatic cpu_op(input bit rd, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_data, input int exp_stall);
        cpu_exp_t e;
        bit done = 1'b0;
        e.rd = rd;
        e.data = exp_data;
        e.stall = exp_stall;
        cpu_q.push_back(e);
        cpu_addr_i = addr;
        cpu_data_i = wdata;
        cpu_MemRead_i = rd;
        cpu_MemWrite_i = ~rd;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk_i);
            if (!cpu_stall_o) done = 1'b1;
        end
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout on access to %0h: stall still %0b, expected 0", addr, cpu_stall_o);
        end
        @(posedge clk_i);
        #1;
        cpu_MemRead_i = 1'b0;
        cpu_MemWrite_i = 1'b0;
    endtask

    task automatic push_mem(input logic [31:0] addr, input bit wr, input logic [31:0] w0,
                            input logic [31:0] w2);
        mem_exp_t m;
        m.addr = addr;
        m.wr = wr;
        m.w0 = w0;
        m.w2 = w2;
        mem_q.push_back(m);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_enable", {63'h0, mem_enable_o}, 64'h0);
        check("rst_write", {63'h0, mem_write_o}, 64'h0);
        check("rst_stall", {63'h0, cpu_stall_o}, 64'h0);
        check("rst_data", {32'h0, cpu_data_o}, 64'h0);
        @(posedge clk_i);
        #1;
        mon_en = 1'b1;

        // Clean miss refill, then hits in the same line
        push_mem(32'h40, 1'b0, 32'h0, 32'h0);
        cpu_op(1'b1, 32'h40, 32'h0, 32'hDEADBEEF, 12);
        cpu_op(1'b1, 32'h44, 32'h0, 32'hA000_0041, 0);
        cpu_op(1'b0, 32'h48, 32'h1234_5678, 32'h0, 0);
        cpu_op(1'b1, 32'h48, 32'h0, 32'h1234_5678, 0);

        // Dirty conflict miss: writeback of 0x40 then refill of 0x240
        push_mem(32'h40, 1'b1, 32'hDEADBEEF, 32'h1234_5678);
        push_mem(32'h240, 1'b0, 32'h0, 32'h0);
        cpu_op(1'b1, 32'h248, 32'h0, 32'hA000_0242, 23);

        // Store miss to an invalid line, word written in DONE
        push_mem(32'h400, 1'b0, 32'h0, 32'h0);
        cpu_op(1'b0, 32'h400, 32'hCAFE_F00D, 32'h0, 12);
        cpu_op(1'b1, 32'h400, 32'h0, 32'hCAFE_F00D, 0);
        cpu_op(1'b1, 32'h404, 32'h0, 32'hA000_0401, 0);
        cpu_op(1'b1, 32'h248, 32'h0, 32'hA000_0242, 0);

        check("cpu_q_empty", 64'(cpu_q.size()), 64'h0);
        check("mem_q_empty", 64'(mem_q.size()), 64'h0);

        // Reset during refill, then a late ack
        mon_en = 1'b0;
        mem_auto = 1'b0;
        cpu_addr_i = 32'h60;
        cpu_MemRead_i = 1'b1;
        @(negedge clk_i);
        check("miss_0x60_stall", {63'h0, cpu_stall_o}, 64'h1);
        repeat (3) @(posedge clk_i);
        #1;
        check("refill_enable", {63'h0, mem_enable_o}, 64'h1);
        check("refill_write", {63'h0, mem_write_o}, 64'h0);
        check("refill_addr", {32'h0, mem_addr_o}, 64'h60);
        rst_i = 1'b1;
        cpu_MemRead_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("post_rst_enable", {63'h0, mem_enable_o}, 64'h0);
        mem_data_i = line_for(32'h60);
        force_ack = 1'b1;
        @(posedge clk_i);
        #1;
        force_ack = 1'b0;
        check("late_ack_enable", {63'h0, mem_enable_o}, 64'h0);
        check("late_ack_write", {63'h0, mem_write_o}, 64'h0);
        cpu_addr_i = 32'h248;
        cpu_MemRead_i = 1'b1;
        @(negedge clk_i);
        check("post_rst_0x248_stall", {63'h0, cpu_stall_o}, 64'h1);
        check("post_rst_0x248_data", {32'h0, cpu_data_o}, 64'h0);
        @(posedge clk_i);
        #1;
        cpu_MemRead_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        cpu_addr_i = 32'h60;
        cpu_MemRead_i = 1'b1;
        @(negedge clk_i);
        check("post_rst_0x60_stall", {63'h0, cpu_stall_o}, 64'h1);
        @(posedge clk_i);
        #1;
        cpu_MemRead_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
